// File: rtl/shiftreg_dyn_rx.sv
// Receive endpoint of the dynamic shift-register configuration link: deserialises
// one MSB-first word, checks its length and commits it on the latch strobe.
module shiftreg_dyn_rx #(
    parameter int                   SIZESRDYN   = 16,
    parameter logic [SIZESRDYN-1:0] DYN_RST_VAL = '0,
    parameter int                   CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 sel_dyn,
    input  logic                 sel_stat,
    input  logic                 en_fin,
    input  logic                 signal_in,
    input  logic                 clr_err,
    output logic [SIZESRDYN-1:0] dyn_cfg,
    output logic                 cfg_valid,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 len_err,
    output logic                 proto_err,
    output logic                 busy
);

    localparam int            CW       = $clog2(SIZESRDYN + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(SIZESRDYN);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SIZESRDYN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [SIZESRDYN-1:0]   dyn_sr_reg;
    logic [CW-1:0]          bit_cnt_reg;
    logic [SIZESRDYN-1:0]   dyn_cfg_reg;
    logic                   cfg_valid_reg;
    logic [CNT_W-1:0]       frame_cnt_reg;
    logic                   len_err_reg;
    logic                   proto_err_reg;
    logic                   busy_reg;

    logic shift_cond;
    logic do_shift, do_commit, set_len, set_proto, clr_sr, clr_cnt;

    assign shift_cond = sel_dyn & ~sel_stat & ~en_fin;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        set_len    = 1'b0;
        set_proto  = 1'b0;
        clr_sr     = 1'b0;
        clr_cnt    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (shift_cond) begin
                    do_shift   = 1'b1;
                    state_next = SHIFT;
                end else if (sel_stat && !sel_dyn) begin
                    set_len = 1'b1;
                end
            end
            SHIFT: begin
                if (en_fin) begin
                    set_proto  = 1'b1;
                    clr_cnt    = 1'b1;
                    state_next = IDLE;
                end else if (sel_dyn && !sel_stat) begin
                    do_shift = 1'b1;
                end else if (!sel_dyn && sel_stat) begin
                    state_next = DONE;
                    if (bit_cnt_reg == CNT_FULL) begin
                        do_commit = 1'b1;
                    end else begin
                        set_len = 1'b1;
                    end
                end else if (sel_dyn && sel_stat) begin
                    set_proto  = 1'b1;
                    clr_sr     = 1'b1;
                    clr_cnt    = 1'b1;
                    state_next = IDLE;
                end else begin
                    set_proto  = 1'b1;
                    clr_cnt    = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                // sel_dyn with en_fin high is the sequencer's post-load wait
                if (!sel_dyn && !en_fin && !sel_stat) begin
                    clr_cnt    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                clr_cnt    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dyn_sr_reg    <= '0;
            bit_cnt_reg   <= '0;
            dyn_cfg_reg   <= DYN_RST_VAL;
            cfg_valid_reg <= 1'b0;
            frame_cnt_reg <= '0;
            len_err_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (clr_sr) begin
                dyn_sr_reg <= '0;
            end else if (do_shift) begin
                dyn_sr_reg <= {dyn_sr_reg[SIZESRDYN-2:0], signal_in};
            end

            if (clr_cnt) begin
                bit_cnt_reg <= '0;
            end else if (do_shift && bit_cnt_reg != CNT_MAX) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            cfg_valid_reg <= do_commit;
            if (do_commit) begin
                dyn_cfg_reg   <= dyn_sr_reg;
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end

            // a new error on the same edge as clr_err leaves the flag set
            len_err_reg   <= set_len   | (len_err_reg   & ~clr_err);
            proto_err_reg <= set_proto | (proto_err_reg & ~clr_err);
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign dyn_cfg   = dyn_cfg_reg;
    assign cfg_valid = cfg_valid_reg;
    assign frame_cnt = frame_cnt_reg;
    assign len_err   = len_err_reg;
    assign proto_err = proto_err_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_shiftreg_dyn_rx.sv
// Scoreboard bench for shiftreg_dyn_rx: expected commits are queued by the
// stimulus thread and popped by a monitor on every cfg_valid pulse.
module tb_shiftreg_dyn_rx;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        sel_dyn, sel_stat, en_fin, signal_in, clr_err;
    logic [15:0] dyn_cfg;
    logic        cfg_valid;
    logic [7:0]  frame_cnt;
    logic        len_err, proto_err, busy;

    typedef struct {
        logic [15:0] cfg;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_cnt;
    int          checks  = 0;
    int          passes  = 0;
    int          commits = 0;

    shiftreg_dyn_rx #(
        .SIZESRDYN  (16),
        .DYN_RST_VAL(16'h0000),
        .CNT_W      (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .sel_dyn  (sel_dyn),
        .sel_stat (sel_stat),
        .en_fin   (en_fin),
        .signal_in(signal_in),
        .clr_err  (clr_err),
        .dyn_cfg  (dyn_cfg),
        .cfg_valid(cfg_valid),
        .frame_cnt(frame_cnt),
        .len_err  (len_err),
        .proto_err(proto_err),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic sd, input logic ss, input logic ef, input logic si, input logic ce);
        @(negedge CLK);
        sel_dyn   = sd;
        sel_stat  = ss;
        en_fin    = ef;
        signal_in = si;
        clr_err   = ce;
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, 1'b0, 1'b0, v[i], 1'b0);
        end
    endtask

    task automatic good_frame(input logic [15:0] v, input int wait_n);
        exp_t e;
        send_bits({16'h0, v}, 16);
        model_cnt = model_cnt + 8'd1;
        e.cfg = v;
        e.cnt = model_cnt;
        exp_q.push_back(e);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < wait_n; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dyn_cfg"},   dyn_cfg,   32'h0);
        chk({tag, "_cfg_valid"}, cfg_valid, 32'h0);
        chk({tag, "_frame_cnt"}, frame_cnt, 32'h0);
        chk({tag, "_len_err"},   len_err,   32'h0);
        chk({tag, "_proto_err"}, proto_err, 32'h0);
        chk({tag, "_busy"},      busy,      32'h0);
    endtask

    // monitor: every cfg_valid pulse must match the oldest queued commit
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (cfg_valid === 1'b1) begin
                commits++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL cfg_valid_unexpected: got cfg_valid=1 dyn_cfg=%0h, expected no commit", dyn_cfg);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("commit_dyn_cfg",   dyn_cfg,   e.cfg);
                    chk("commit_frame_cnt", frame_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        sel_dyn = 1'b0; sel_stat = 1'b0; en_fin = 1'b0; signal_in = 1'b0; clr_err = 1'b0;
        model_cnt = 8'd0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk_reset_vals("reset");
        RST_N = 1'b1;

        // good frame with the sequencer's long post-load wait
        good_frame(16'h1234, 21);
        settle();
        chk("good_dyn_cfg",   dyn_cfg,   32'h1234);
        chk("good_frame_cnt", frame_cnt, 32'd1);
        chk("good_len_err",   len_err,   32'h0);
        chk("good_proto_err", proto_err, 32'h0);
        chk("good_busy_low",  busy,      32'h0);

        // short frame
        send_bits(32'h7FFF, 15);
        settle();
        chk("short_busy_high", busy, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("short_len_err",   len_err,   32'h1);
        chk("short_dyn_cfg",   dyn_cfg,   32'h1234);
        chk("short_frame_cnt", frame_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("clr_len_err", len_err, 32'h0);

        // long frame, bit count saturates past the word length
        send_bits(32'h1ABCD, 17);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("long_len_err",   len_err,   32'h1);
        chk("long_dyn_cfg",   dyn_cfg,   32'h1234);
        chk("long_frame_cnt", frame_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // both strobes high mid-shift
        send_bits(32'h15, 5);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        chk("proto_both_err",  proto_err, 32'h1);
        chk("proto_both_busy", busy,      32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        good_frame(16'hFFFF, 3);
        settle();
        chk("after_proto_dyn_cfg",   dyn_cfg,   32'hFFFF);
        chk("after_proto_frame_cnt", frame_cnt, 32'd2);
        chk("after_proto_err_kept",  proto_err, 32'h1);

        // abort by dropping sel_dyn
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("clr_proto_err", proto_err, 32'h0);
        chk("clr_len_err2",  len_err,   32'h0);
        send_bits(32'hC3, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("abort_proto_err", proto_err, 32'h1);
        chk("abort_busy",      busy,      32'h0);

        // reset in the middle of a frame
        send_bits(32'h2AA, 10);
        settle();
        chk("midframe_busy", busy, 32'h1);
        @(negedge CLK);
        RST_N = 1'b0;
        sel_dyn = 1'b0;
        settle();
        chk_reset_vals("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        model_cnt = 8'd0;
        commits = 0;

        // frame counter wrap
        for (int i = 0; i < 256; i++) begin
            good_frame(16'(i * 16'h0101) ^ 16'h5A5A, 2);
        end
        settle();
        chk("wrap_frame_cnt", frame_cnt, 32'd0);
        chk("wrap_commits",   commits,   32'd256);
        chk("wrap_dyn_cfg",   dyn_cfg,   32'hA5A5);

        // zero-length frame and error-vs-clear priority
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("zero_len_err",  len_err, 32'h1);
        chk("zero_len_busy", busy,    32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("prio_pre_clear", len_err, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("prio_err_wins", len_err, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
